fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the first fetch address after reset.
REQ-002 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 imem_addr  output  16  fetch address to the combinational instruction ROM; always equals the internal PC.
REQ-005 imem_instr  input  16  ROM data for imem_addr, valid in the same cycle.
REQ-006 out_valid  output  1  out_instr and out_pc hold a fetched instruction.
REQ-007 out_ready  input  1  downstream decode accepts the instruction this cycle.
REQ-008 out_instr  output  16  fetched instruction word.
REQ-009 out_pc  output  16  address out_instr was fetched from.
REQ-010 redirect_valid  input  1  branch or jump taken; load redirect_pc.
REQ-011 redirect_pc  input  16  new fetch address.
REQ-012 halt_req  input  1  stop fetching after the current cycle.
REQ-013 halted  output  1  high while in HALT.
REQ-014 fetch_count  output  16  count of accepted instructions; present only under FETCH_PERF_CNT_EN.

Function
REQ-015 FSM states: BOOT, RUN, HALT.
- BOOT->RUN unconditionally on the first edge after reset release.
- RUN->HALT when halt_req=1 and redirect_valid=0.
- Any state->RUN when redirect_valid=1.
REQ-016 Load condition: state=RUN, redirect_valid=0, halt_req=0, and (out_valid=0 or out_ready=1).
REQ-017 On a load: out_instr<=imem_instr; out_pc<=PC; out_valid<=1; PC<=PC+1.
REQ-018 PC increments modulo 2^16: 16'hFFFF wraps to 16'h0000 with no flag.
REQ-019 Transfer occurs when out_valid=1 and out_ready=1; without a simultaneous load, out_valid<=0 after the edge.
REQ-020 While out_valid=1 and out_ready=0: out_instr, out_pc and PC hold stable.
REQ-021 Redirect (redirect_valid=1), highest priority:
- out_valid<=0 (flush, even if out_ready=1 that cycle; no transfer counted);
- PC<=redirect_pc.
REQ-022 Fetch from the redirect target begins on the following RUN cycle, giving a one-cycle bubble.
REQ-023 halt_req=1 blocks loads in the same cycle; a pending out_valid entry is held until accepted.
REQ-024 halted=1 exactly while the state is HALT; only redirect_valid leaves HALT.
REQ-025 Latency from reset release: out_valid first rises after the second rising edge, with out_pc=RESET_PC.
REQ-026 Sustained throughput is one instruction per cycle while out_ready=1.

Reset
REQ-027 rst_n=0 immediately forces:
- PC=RESET_PC, state=BOOT;
- out_valid=0, out_instr=16'h0000, out_pc=16'h0000;
- halted=0, fetch_count=0.
REQ-028 Reset asserted mid-transfer discards the held instruction; no partial state survives.

Configuration
REQ-029 With FETCH_PERF_CNT_EN defined, port fetch_count exists and increments by 1 on each transfer, wrapping at 16'hFFFF->0.
REQ-030 Without FETCH_PERF_CNT_EN, the port and counter are absent; all other behaviour is identical.

Structure
REQ-031 Shared package cpu_pkg holds:
- FSM state typedef;
- ADDR_W=16 and INSTR_W=16;
- NOP encoding 16'h0000.
REQ-032 The PC register and its next-PC mux form sub-module fetch_pc; the FSM and output register stay in fetch_unit.

Verification
REQ-033 Reset release, out_ready=1, ROM[0..2]=0000/0001/0002: out_valid rises on edge 2; out_pc 0,1,2 on consecutive cycles.
REQ-034 out_ready=0 for 3 cycles at out_pc=1: out_instr=0001 and imem_addr=2 stay stable; the next edge after ready returns delivers out_pc=2.
REQ-035 redirect_valid=1, redirect_pc=16'h0040, while out_valid=1 and out_ready=1:
- out_valid=0 for one cycle;
- next out_pc=16'h0040;
- fetch_count not incremented for the flushed word.
REQ-036 halt_req pulse in RUN: halted=1 and no new loads; redirect_pc=16'h0010 then resumes with out_pc=16'h0010.
REQ-037 redirect_pc=16'hFFFF, out_ready=1: out_pc sequence FFFF then 0000.
REQ-038 rst_n dropped mid-stream while out_valid=1: out_valid=0 and imem_addr=RESET_PC immediately, before any clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, encodings and FSM state type for the fetch path
//
// Purpose : common definitions imported by fetch_unit and fetch_pc.
// Contents: ADDR_W / INSTR_W widths, NOP encoding, fetch FSM state type
//           and constants, next-sequential-PC helper.
package cpu_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP = 16'h0000;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_BOOT = 2'd0;
  localparam fsm_state_t ST_RUN  = 2'd1;
  localparam fsm_state_t ST_HALT = 2'd2;

  // Sequential fetch address; wraps silently at the top of the address space.
  function automatic logic [ADDR_W-1:0] pc_next_seq(input logic [ADDR_W-1:0] pc);
    return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - program counter register and next-PC selection
//
// Purpose : holds the fetch PC; loads redirect_pc on a redirect, advances by
//           one on a fetch load, otherwise holds.
// Ports   : clk, rst_n     - clock, asynchronous active-low reset
//           load        - a fetch load happens this cycle (advance PC)
//           redirect    - branch/jump taken (highest priority)
//           redirect_pc - new fetch address
//           pc          - current fetch address
module fetch_pc
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (load) begin
      pc_d = pc_next_seq(pc_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with one-entry output register
//
// Purpose : fetches from a combinational instruction ROM and presents one
//           instruction at a time to decode with a valid/ready handshake.
//           Supports redirect (flush + new PC) and halt.
// Optional: FETCH_PERF_CNT_EN adds the fetch_count port (accepted transfers).
// Ports   : clk, rst_n                  - clock, asynchronous active-low reset
//           imem_addr / imem_instr      - ROM address (= PC) and its data
//           out_valid / out_ready       - output handshake
//           out_instr / out_pc          - fetched word and its address
//           redirect_valid / redirect_pc- taken branch/jump and its target
//           halt_req / halted           - stop request and HALT indication
//           fetch_count                 - transfer counter (optional)
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [ADDR_W-1:0]  fetch_count
`endif
);

  fsm_state_t         state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
  logic [ADDR_W-1:0]  pc;
  logic               load;
  logic               xfer;

  // A redirect flushes the output register, so a word presented in the same
  // cycle as a redirect is never considered transferred.
  assign load = (state_q == ST_RUN) && !redirect_valid && !halt_req &&
                (!out_valid_q || out_ready);
  assign xfer = out_valid_q && out_ready && !redirect_valid;

  fetch_pc #(
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .redirect    (redirect_valid),
    .redirect_pc (redirect_pc),
    .pc          (pc)
  );

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN:  if (halt_req) state_d = ST_HALT;
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_BOOT;
      endcase
    end
  end

  // Load and transfer in the same cycle keeps out_valid high (back-to-back
  // throughput); a transfer alone drains the register.
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    if (redirect_valid) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      out_instr_d = imem_instr;
      out_pc_d    = pc;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      out_valid_q <= 1'b0;
      out_instr_q <= NOP;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [ADDR_W-1:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (xfer) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

  assign imem_addr = pc;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt_req;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_xfer = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // ROM: words 0..2 hold their own address, everything else is scrambled
  function automatic logic [15:0] rom(input logic [15:0] a);
    return (a < 16'd3) ? a : (a ^ 16'hC3A5);
  endfunction

  assign imem_instr = rom(imem_addr);

  fetch_unit #(
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] pc, input logic [15:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted word must match the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready && !redirect_valid) begin
        n_xfer++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_xfer: got pc %h instr %h expected none", out_pc, out_instr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("xfer_pc", out_pc, e.pc);
          chk("xfer_instr", out_instr, e.instr);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    halt_req       = 1'b0;
    step();
    step();
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_imem_addr", imem_addr, 16'h0000);
    chk("rst_out_pc", out_pc, 16'h0000);
    chk("rst_out_instr", out_instr, 16'h0000);
    chk("rst_halted", {15'd0, halted}, 16'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fetch_count", fetch_count, 16'd0);
`endif

    // Startup latency and back-to-back fetch
    push(16'h0000, 16'h0000);
    push(16'h0001, 16'h0001);
    push(16'h0002, 16'h0002);
    rst_n = 1'b1;
    step();
    chk("boot_valid_low", {15'd0, out_valid}, 16'd0);
    step();
    chk("first_valid", {15'd0, out_valid}, 16'd1);
    chk("first_pc", out_pc, 16'h0000);
    step();
    chk("second_pc", out_pc, 16'h0001);

    // Backpressure: hold out_pc=1 for three cycles
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", out_pc, 16'h0001);
      chk("stall_instr", out_instr, 16'h0001);
      chk("stall_imem_addr", imem_addr, 16'h0002);
    end
    out_ready = 1'b1;
    step();
    chk("resume_pc", out_pc, 16'h0002);

    // Redirect while a word is being offered and accepted: word 3 is flushed
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    step();
    redirect_valid = 1'b0;
    chk("flush_valid", {15'd0, out_valid}, 16'd0);
    chk("redir_imem_addr", imem_addr, 16'h0040);
`ifdef FETCH_PERF_CNT_EN
    chk("flush_count", fetch_count, 16'd3);
`endif
    push(16'h0040, 16'hC3E5);
    push(16'h0041, 16'hC3E4);
    step();
    chk("redir_pc", out_pc, 16'h0040);
    step();

    // Halt pulse: pending 0x41 drains, no further loads
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("halted_on", {15'd0, halted}, 16'd1);
    chk("halt_valid", {15'd0, out_valid}, 16'd0);
    step();
    step();
    chk("halted_hold", {15'd0, halted}, 16'd1);
    chk("halt_no_load", {15'd0, out_valid}, 16'd0);
    chk("halt_pc_hold", imem_addr, 16'h0042);

    // Resume from HALT via redirect
    push(16'h0010, 16'hC3B5);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0010;
    step();
    redirect_valid = 1'b0;
    chk("halted_off", {15'd0, halted}, 16'd0);
    step();
    chk("resume_redir_pc", out_pc, 16'h0010);
    step();

    // Address wrap: FFFF then 0000 then 0001
    push(16'hFFFF, 16'h3C5A);
    push(16'h0000, 16'h0000);
    push(16'h0001, 16'h0001);
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFF;
    step();
    redirect_valid = 1'b0;
    step();
    chk("wrap_pc_ffff", out_pc, 16'hFFFF);
    step();
    chk("wrap_pc_0000", out_pc, 16'h0000);
    step();
    step();

    // Asynchronous reset while a word is pending
    out_ready = 1'b0;
    chk("pre_rst_valid", {15'd0, out_valid}, 16'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("pre_rst_count", fetch_count, 16'd9);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {15'd0, out_valid}, 16'd0);
    chk("async_rst_imem_addr", imem_addr, 16'h0000);
    chk("async_rst_out_pc", out_pc, 16'h0000);
    chk("async_rst_out_instr", out_instr, 16'h0000);
`ifdef FETCH_PERF_CNT_EN
    chk("async_rst_count", fetch_count, 16'd0);
`endif

    // Restart after reset: stale word must not reappear
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    push(16'h0000, 16'h0000);
    step();
    step();
    chk("restart_pc", out_pc, 16'h0000);
    step();
    out_ready = 1'b0;
    step();

    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
